draw_letters: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_delay.sv | 25 ++
 rtl/draw_letters.sv | 95 +++++++++
 tb/tb_draw_letters.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA stream type and board-label window constants used by the label address
// generator and the draw_letters overlay stage.
package vga_pkg;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   localparam int VGA_W = $bits(vga_t);

   localparam logic [11:0] LETTER_COLOR_DEF = 12'hFFF;
   localparam logic [11:0] SHADOW_COLOR     = 12'h333;

   // File labels (A-H) sit above and below the board
   localparam logic [10:0] FILE_H_MIN     = 11'd256;
   localparam logic [10:0] FILE_H_MAX     = 11'd768;
   localparam logic [10:0] FILE_V_TOP_MIN = 11'd104;
   localparam logic [10:0] FILE_V_TOP_MAX = 11'd120;
   localparam logic [10:0] FILE_V_BOT_MIN = 11'd648;
   localparam logic [10:0] FILE_V_BOT_MAX = 11'd664;
   localparam logic [5:0]  FILE_COL_MIN   = 6'd28;
   localparam logic [5:0]  FILE_COL_MAX   = 6'd35;

   // Rank labels (1-8) sit left and right of the board
   localparam logic [10:0] RANK_V_MIN     = 11'd128;
   localparam logic [10:0] RANK_V_MAX     = 11'd640;
   localparam logic [10:0] RANK_H_L_MIN   = 11'd236;
   localparam logic [10:0] RANK_H_L_MAX   = 11'd244;
   localparam logic [10:0] RANK_H_R_MIN   = 11'd780;
   localparam logic [10:0] RANK_H_R_MAX   = 11'd788;
   localparam logic [5:0]  RANK_ROW_MIN   = 6'd24;
   localparam logic [5:0]  RANK_ROW_MAX   = 6'd40;

endpackage

// File: rtl/vga_delay.sv
// Reset-clearable DEPTH-stage delay line for a packed VGA stream word.
module vga_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/draw_letters.sv
// Overlays A-H / 1-8 board label glyphs onto the VGA stream, realigned to font ROM latency.
// Optional 1-px drop shadow enabled by defining LETTER_SHADOW_EN.
module draw_letters
   import vga_pkg::*;
#(
   parameter int          ROM_LATENCY  = 1,
   parameter logic [11:0] LETTER_COLOR = LETTER_COLOR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_pixels,
   input  logic [10:0] vga_in_hcount,
   input  logic [10:0] vga_in_vcount,
   input  logic        vga_in_hsync,
   input  logic        vga_in_vsync,
   input  logic        vga_in_hblnk,
   input  logic        vga_in_vblnk,
   input  logic [11:0] vga_in_rgb,
   output logic [10:0] vga_out_hcount,
   output logic [10:0] vga_out_vcount,
   output logic        vga_out_hsync,
   output logic        vga_out_vsync,
   output logic        vga_out_hblnk,
   output logic        vga_out_vblnk,
   output logic [11:0] vga_out_rgb
);

   vga_t in_px, d_px, nxt_px, out_px;
   logic [5:0] h_mod, v_mod;
   logic       file_win, rank_l, rank_r, rank_win, win_active, glyph_on;
   logic [3:0] x;

   assign in_px = '{hcount: vga_in_hcount, vcount: vga_in_vcount,
                    hsync: vga_in_hsync, vsync: vga_in_vsync,
                    hblnk: vga_in_hblnk, vblnk: vga_in_vblnk, rgb: vga_in_rgb};

   vga_delay #(.DEPTH(ROM_LATENCY), .WIDTH(VGA_W)) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (in_px),
      .dout (d_px)
   );

   always_comb begin
      h_mod    = d_px.hcount[5:0];
      v_mod    = d_px.vcount[5:0];
      file_win = (d_px.hcount >= FILE_H_MIN) && (d_px.hcount <= FILE_H_MAX) &&
                 (((d_px.vcount >= FILE_V_TOP_MIN) && (d_px.vcount <= FILE_V_TOP_MAX)) ||
                  ((d_px.vcount >= FILE_V_BOT_MIN) && (d_px.vcount <= FILE_V_BOT_MAX))) &&
                 (h_mod >= FILE_COL_MIN) && (h_mod <= FILE_COL_MAX);
      rank_l   = (d_px.hcount >= RANK_H_L_MIN) && (d_px.hcount <= RANK_H_L_MAX);
      rank_r   = (d_px.hcount >= RANK_H_R_MIN) && (d_px.hcount <= RANK_H_R_MAX);
      rank_win = (d_px.vcount >= RANK_V_MIN) && (d_px.vcount <= RANK_V_MAX) &&
                 (v_mod >= RANK_ROW_MIN) && (v_mod <= RANK_ROW_MAX) && (rank_l || rank_r);
      // File window takes priority should both ever decode
      if (file_win)    x = 4'(h_mod - FILE_COL_MIN);
      else if (rank_l) x = 4'(d_px.hcount - RANK_H_L_MIN);
      else             x = 4'(d_px.hcount - RANK_H_R_MIN);
      win_active = file_win || rank_win;
      // x = 8 is the spacer column of a rank window and never lights
      glyph_on   = win_active && !x[3] && char_pixels[3'd7 - x[2:0]];
   end

`ifdef LETTER_SHADOW_EN
   logic shadow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) shadow_q <= 1'b0;
      else     shadow_q <= glyph_on;
   end
`endif

   always_comb begin
      nxt_px = d_px;
      if (d_px.hblnk || d_px.vblnk) nxt_px.rgb = 12'h000;
      else if (glyph_on)            nxt_px.rgb = LETTER_COLOR;
`ifdef LETTER_SHADOW_EN
      else if (shadow_q)            nxt_px.rgb = SHADOW_COLOR;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_px <= '0;
      else     out_px <= nxt_px;
   end

   assign vga_out_hcount = out_px.hcount;
   assign vga_out_vcount = out_px.vcount;
   assign vga_out_hsync  = out_px.hsync;
   assign vga_out_vsync  = out_px.vsync;
   assign vga_out_hblnk  = out_px.hblnk;
   assign vga_out_vblnk  = out_px.vblnk;
   assign vga_out_rgb    = out_px.rgb;

endmodule

// File: tb/tb_draw_letters.sv
// Directed bench for draw_letters at ROM_LATENCY = 1 (input-to-output latency 2 cycles).
module tb_draw_letters;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  char_pixels = '0;
   logic [10:0] vga_in_hcount = '0, vga_in_vcount = '0;
   logic        vga_in_hsync = 0, vga_in_vsync = 0, vga_in_hblnk = 0, vga_in_vblnk = 0;
   logic [11:0] vga_in_rgb = '0;
   logic [10:0] vga_out_hcount, vga_out_vcount;
   logic        vga_out_hsync, vga_out_vsync, vga_out_hblnk, vga_out_vblnk;
   logic [11:0] vga_out_rgb;

   int total = 0;
   int bad   = 0;

   draw_letters dut (
      .clk            (clk),
      .rst            (rst),
      .char_pixels    (char_pixels),
      .vga_in_hcount  (vga_in_hcount),
      .vga_in_vcount  (vga_in_vcount),
      .vga_in_hsync   (vga_in_hsync),
      .vga_in_vsync   (vga_in_vsync),
      .vga_in_hblnk   (vga_in_hblnk),
      .vga_in_vblnk   (vga_in_vblnk),
      .vga_in_rgb     (vga_in_rgb),
      .vga_out_hcount (vga_out_hcount),
      .vga_out_vcount (vga_out_vcount),
      .vga_out_hsync  (vga_out_hsync),
      .vga_out_vsync  (vga_out_vsync),
      .vga_out_hblnk  (vga_out_hblnk),
      .vga_out_vblnk  (vga_out_vblnk),
      .vga_out_rgb    (vga_out_rgb)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vga_t p);
      vga_in_hcount = p.hcount;
      vga_in_vcount = p.vcount;
      vga_in_hsync  = p.hsync;
      vga_in_vsync  = p.vsync;
      vga_in_hblnk  = p.hblnk;
      vga_in_vblnk  = p.vblnk;
      vga_in_rgb    = p.rgb;
   endtask

   function automatic vga_t px(input int h, input int v, input bit hs, input bit vs,
                               input bit hb, input bit vb, input logic [11:0] rgb);
      vga_t p;
      p.hcount = 11'(h);
      p.vcount = 11'(v);
      p.hsync  = hs;
      p.vsync  = vs;
      p.hblnk  = hb;
      p.vblnk  = vb;
      p.rgb    = rgb;
      return p;
   endfunction

   function automatic vga_t out_now();
      return px(int'(vga_out_hcount), int'(vga_out_vcount), vga_out_hsync, vga_out_vsync,
                vga_out_hblnk, vga_out_vblnk, vga_out_rgb);
   endfunction

   // Independent reference of the label overlay rules
   function automatic logic [11:0] ref_rgb(input vga_t p, input logic [7:0] cp);
      int h = int'(p.hcount);
      int v = int'(p.vcount);
      int col = -1;
      if (p.hblnk || p.vblnk) return 12'h000;
      if (h >= 256 && h <= 768 && ((v >= 104 && v <= 120) || (v >= 648 && v <= 664)) &&
          (h % 64) >= 28 && (h % 64) <= 35)
         col = (h % 64) - 28;
      else if (v >= 128 && v <= 640 && (v % 64) >= 24 && (v % 64) <= 40) begin
         if (h >= 236 && h <= 244)      col = h - 236;
         else if (h >= 780 && h <= 788) col = h - 780;
      end
      if (col >= 0 && col <= 7 && cp[7-col]) return 12'hFFF;
      return p.rgb;
   endfunction

   function automatic logic [7:0] rom(input vga_t p);
      return 8'(int'(p.hcount) * 37 + int'(p.vcount) * 11);
   endfunction

   task automatic test_reset;
      vga_t o;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(px($urandom_range(2047), $urandom_range(2047), 1, 1, 1, 1, 12'($urandom)));
         char_pixels = 8'($urandom);
         step();
         total++;
         o = out_now();
         if (o !== '0) begin
            bad++;
            $display("FAIL reset_hold: got %h expected 0", o);
         end
      end
      rst = 1'b0;
      drive(px(5, 7, 1, 0, 0, 0, 12'hABC));
      char_pixels = 8'h00;
      step();
      drive('0);
      total++;
      o = out_now();
      if (o !== '0) begin
         bad++;
         $display("FAIL reset_zero_gap: got %h expected 0", o);
      end
      step();
      total++;
      o = out_now();
      if (o !== px(5, 7, 1, 0, 0, 0, 12'hABC)) begin
         bad++;
         $display("FAIL reset_first_pixel: got %h expected %h", o, px(5, 7, 1, 0, 0, 0, 12'hABC));
      end
   endtask

   task automatic test_pixel(input string name, input vga_t p, input logic [7:0] cp,
                             input logic [11:0] exp_rgb);
      vga_t o;
      drive(p);
      step();
      drive('0);
      char_pixels = cp;
      step();
      o = out_now();
      total++;
      if (o.rgb !== exp_rgb) begin
         bad++;
         $display("FAIL %s_rgb: got %h expected %h", name, o.rgb, exp_rgb);
      end
      total++;
      if ({o.hcount, o.vcount, o.hsync, o.vsync, o.hblnk, o.vblnk} !==
          {p.hcount, p.vcount, p.hsync, p.vsync, p.hblnk, p.vblnk}) begin
         bad++;
         $display("FAIL %s_timing: got %h expected %h", name, o, p);
      end
   endtask

   task automatic test_glyphs;
      test_pixel("file_on",   px(284, 110, 0, 0, 0, 0, 12'h0A0), 8'h80, 12'hFFF);
      test_pixel("file_off",  px(284, 110, 0, 0, 0, 0, 12'h0A0), 8'h7F, 12'h0A0);
      test_pixel("file_x7",   px(291, 650, 0, 0, 0, 0, 12'h123), 8'h01, 12'hFFF);
      test_pixel("rank_col9", px(244, 152, 0, 0, 0, 0, 12'h0A0), 8'hFF, 12'h0A0);
      test_pixel("rank_x7",   px(243, 152, 0, 0, 0, 0, 12'h0A0), 8'hFF, 12'hFFF);
      test_pixel("rank_r_x0", px(780, 600, 0, 0, 0, 0, 12'h456), 8'h80, 12'hFFF);
      test_pixel("outside",   px(300, 300, 0, 0, 0, 0, 12'h789), 8'hFF, 12'h789);
   endtask

   task automatic test_blanking;
      test_pixel("hblank", px(284, 110, 1, 1, 1, 0, 12'h0A0), 8'hFF, 12'h000);
      test_pixel("vblank", px(243, 152, 0, 1, 0, 1, 12'hF0F), 8'hFF, 12'h000);
   endtask

   task automatic test_mid_reset;
      vga_t o;
      drive(px(284, 110, 0, 0, 0, 0, 12'h0A0));
      step();
      char_pixels = 8'h80;
      step();
      o = out_now();
      total++;
      if (o.rgb !== 12'hFFF) begin
         bad++;
         $display("FAIL midrst_pre: got %h expected fff", o.rgb);
      end
      rst = 1'b1;
      #1;
      o = out_now();
      total++;
      if (o !== '0) begin
         bad++;
         $display("FAIL midrst_async: got %h expected 0", o);
      end
      rst = 1'b0;
      drive('0);
      step();
      o = out_now();
      total++;
      if (o !== '0) begin
         bad++;
         $display("FAIL midrst_no_partial: got %h expected 0", o);
      end
   endtask

   function automatic vga_t frame_px(input int h, input int v);
      return px(h, v, (h >= 810 && h <= 820), (v == 770), (h >= 800), (v == 770),
                12'(h ^ (v << 2)));
   endfunction

   task automatic test_frame;
      int   rows [6] = '{110, 152, 300, 660, 170, 770};
      int   npx = 6 * 631;
      vga_t cur, prev, exp_q, o;
      bit   prev_ok = 0, exp_ok = 0;
      logic [7:0] cp;
      prev = '0;
      exp_q = '0;
      for (int i = 0; i < npx + 2; i++) begin
         if (exp_ok) begin
            o = out_now();
            total++;
            if (o !== exp_q) begin
               bad++;
               $display("FAIL frame_px h=%0d v=%0d: got %h expected %h",
                        exp_q.hcount, exp_q.vcount, o, exp_q);
            end
         end
         if (prev_ok) begin
            cp = rom(prev);
            exp_q = prev;
            exp_q.rgb = ref_rgb(prev, cp);
            exp_ok = 1;
         end else begin
            cp = 8'h00;
            exp_ok = 0;
         end
         if (i < npx) begin
            cur = frame_px(200 + i % 631, rows[i / 631]);
            prev_ok = 1;
         end else begin
            cur = '0;
            prev_ok = 0;
         end
         drive(cur);
         char_pixels = cp;
         prev = cur;
         step();
      end
   endtask

`ifdef LETTER_SHADOW_EN
   task automatic test_shadow;
      vga_t o;
      logic [11:0] exp_seq [3] = '{12'hFFF, SHADOW_COLOR, 12'h0A0};
      char_pixels = 8'h80;
      for (int i = 0; i < 5; i++) begin
         if (i >= 2) begin
            o = out_now();
            total++;
            if (o.rgb !== exp_seq[i-2]) begin
               bad++;
               $display("FAIL shadow_x%0d: got %h expected %h", i - 2, o.rgb, exp_seq[i-2]);
            end
         end
         if (i < 3) drive(px(284 + i, 110, 0, 0, 0, 0, 12'h0A0));
         else       drive('0);
         step();
      end
      drive(px(284, 110, 0, 0, 0, 0, 12'h0A0));
      step();
      drive(px(285, 110, 0, 0, 0, 0, 12'h0A0));
      step();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      drive('0);
      step();
      o = out_now();
      total++;
      if (o.rgb !== 12'h000) begin
         bad++;
         $display("FAIL shadow_after_rst: got %h expected 000", o.rgb);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_glyphs();
      test_blanking();
      test_mid_reset();
      test_frame();
`ifdef LETTER_SHADOW_EN
      test_shadow();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
